// File: rtl/led_status_seq.sv
// led_status_seq: door-lock status indicator sequencer.
// Maps lock-controller events to an RGB colour code plus blink request.
//
// Ports:
//   clk_in      system clock
//   rst         synchronous active-high reset
//   evt_ok      pulse: password accepted
//   evt_fail    pulse: password rejected
//   evt_lock    pulse: door re-locked
//   setup_mode  level: password-change mode
//   alarm_clr   pulse: admin clears alarm
//   led_rgb     colour (OFF 000 RED 001 GREEN 010 YELLOW 011 BLUE 100 WHITE 111)
//   rgb_toggle  blink request
//   alarm       high in ALARM
//   busy        high in OPEN, FAIL, ALARM, SETUP
module led_status_seq #(
    parameter logic [27:0] TICK_DIV   = 28'd50_000_000,
    parameter int          OPEN_TICKS = 5,
    parameter int          FAIL_TICKS = 3,
    parameter int          MAX_FAIL   = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       evt_ok,
    input  logic       evt_fail,
    input  logic       evt_lock,
    input  logic       setup_mode,
    input  logic       alarm_clr,
    output logic [2:0] led_rgb,
    output logic       rgb_toggle,
    output logic       alarm,
    output logic       busy
);

    localparam int TMAX = (OPEN_TICKS > FAIL_TICKS) ? OPEN_TICKS : FAIL_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    localparam logic [2:0] C_OFF    = 3'b000;
    localparam logic [2:0] C_RED    = 3'b001;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b011;
    localparam logic [2:0] C_BLUE   = 3'b100;
    localparam logic [2:0] C_WHITE  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_FAIL,
        S_ALARM,
        S_SETUP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [27:0]   presc;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_load;
    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_inc;
    logic          tick;
    logic          timeout;
    logic          enter;
    logic          cnt_inc;
    logic          cnt_clr;
    state_t        fail_dst;

    logic [2:0]    led_n;
    logic          toggle_n;
    logic          alarm_n;
    logic          busy_n;

    assign tick    = (presc == TICK_DIV - 28'd1);
    assign timeout = tick && (timer == TW'(1));

    // Saturating increment; the destination of a failure depends on
    // whether this increment reaches the alarm threshold.
    assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt
                                                  : fail_cnt + FW'(1);
    assign fail_dst = (fail_inc == FW'(MAX_FAIL)) ? S_ALARM : S_FAIL;

    always_comb begin
        state_n = state;
        enter   = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (evt_fail) begin
                    state_n = fail_dst;
                    enter   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (evt_ok) begin
                    state_n = S_OPEN;
                    enter   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (setup_mode) begin
                    state_n = S_SETUP;
                    enter   = 1'b1;
                end
            end
            S_OPEN: begin
                if (evt_fail) begin
                    state_n = fail_dst;
                    enter   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (evt_ok) begin
                    // Re-entry restarts the open window.
                    state_n = S_OPEN;
                    enter   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (evt_lock || timeout) begin
                    state_n = S_IDLE;
                    enter   = 1'b1;
                end
            end
            S_FAIL: begin
                if (evt_fail) begin
                    state_n = fail_dst;
                    enter   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (timeout) begin
                    state_n = S_IDLE;
                    enter   = 1'b1;
                end
            end
            S_ALARM: begin
                if (alarm_clr) begin
                    state_n = S_IDLE;
                    enter   = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            S_SETUP: begin
                if (!setup_mode) begin
                    state_n = S_IDLE;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                enter   = 1'b1;
            end
        endcase
    end

    always_comb begin
        timer_load = '0;
        if (state_n == S_OPEN) begin
            timer_load = TW'(OPEN_TICKS);
        end else if (state_n == S_FAIL) begin
            timer_load = TW'(FAIL_TICKS);
        end
    end

    always_comb begin
        led_n    = C_BLUE;
        toggle_n = 1'b0;
        alarm_n  = 1'b0;
        busy_n   = 1'b1;
        unique case (state_n)
            S_IDLE:  busy_n = 1'b0;
            S_OPEN:  led_n  = C_GREEN;
            S_FAIL: begin
                led_n    = C_RED;
                toggle_n = 1'b1;
            end
            S_ALARM: begin
                led_n    = C_WHITE;
                toggle_n = 1'b1;
                alarm_n  = 1'b1;
            end
            S_SETUP: begin
                led_n    = C_YELLOW;
                toggle_n = 1'b1;
            end
            default: begin
                led_n  = C_OFF;
                busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Any state entry, including re-entry, restarts the tick phase so a
    // timed state lasts exactly N*TICK_DIV cycles.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            presc <= '0;
            timer <= '0;
        end else if (enter) begin
            presc <= '0;
            timer <= timer_load;
        end else begin
            presc <= tick ? 28'd0 : presc + 28'd1;
            if (tick && timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst || cnt_clr) begin
            fail_cnt <= '0;
        end else if (cnt_inc) begin
            fail_cnt <= fail_inc;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            led_rgb    <= C_OFF;
            rgb_toggle <= 1'b0;
            alarm      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            led_rgb    <= led_n;
            rgb_toggle <= toggle_n;
            alarm      <= alarm_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_led_status_seq.sv
// tb_led_status_seq: directed bench for led_status_seq.
// Observed word is {led_rgb, rgb_toggle, alarm, busy}.
module tb_led_status_seq;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       evt_ok = 1'b0;
    logic       evt_fail = 1'b0;
    logic       evt_lock = 1'b0;
    logic       setup_mode = 1'b0;
    logic       alarm_clr = 1'b0;
    logic [2:0] led_rgb;
    logic       rgb_toggle;
    logic       alarm;
    logic       busy;
    logic [5:0] obs;

    int n_run = 0;
    int n_fail = 0;

    localparam logic [5:0] OFF    = 6'b000_000;
    localparam logic [5:0] BLUE   = 6'b100_000;
    localparam logic [5:0] GREEN  = 6'b010_001;
    localparam logic [5:0] RED    = 6'b001_101;
    localparam logic [5:0] WHITE  = 6'b111_111;
    localparam logic [5:0] YELLOW = 6'b011_101;

    led_status_seq #(
        .TICK_DIV(28'd4),
        .OPEN_TICKS(5),
        .FAIL_TICKS(3),
        .MAX_FAIL(3)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .evt_ok(evt_ok),
        .evt_fail(evt_fail),
        .evt_lock(evt_lock),
        .setup_mode(setup_mode),
        .alarm_clr(alarm_clr),
        .led_rgb(led_rgb),
        .rgb_toggle(rgb_toggle),
        .alarm(alarm),
        .busy(busy)
    );

    assign obs = {led_rgb, rgb_toggle, alarm, busy};

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [5:0] got,
                       input logic [5:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic hold(input string tag, input logic [5:0] exp,
                        input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, obs, exp);
        end
    endtask

    task automatic p_ok();
        evt_ok = 1'b1;
        step(1);
        evt_ok = 1'b0;
    endtask

    task automatic p_fail();
        evt_fail = 1'b1;
        step(1);
        evt_fail = 1'b0;
    endtask

    task automatic p_lock();
        evt_lock = 1'b1;
        step(1);
        evt_lock = 1'b0;
    endtask

    initial begin
        #1;
        step(3);
        chk("reset", obs, OFF);
        rst = 1'b0;
        step(1);
        chk("post_reset", obs, BLUE);

        p_ok();
        chk("ok_green", obs, GREEN);
        hold("open_hold", GREEN, 19);
        step(1);
        chk("open_timeout", obs, BLUE);

        p_ok();
        step(5);
        chk("open_pre_lock", obs, GREEN);
        p_lock();
        chk("lock_blue", obs, BLUE);

        p_ok();
        hold("open_a", GREEN, 10);
        p_ok();
        chk("reopen", obs, GREEN);
        hold("reopen_hold", GREEN, 19);
        step(1);
        chk("reopen_timeout", obs, BLUE);

        p_fail();
        chk("fail1", obs, RED);
        hold("fail1_hold", RED, 11);
        step(1);
        chk("fail1_end", obs, BLUE);
        step(7);
        p_fail();
        chk("fail2", obs, RED);
        hold("fail2_hold", RED, 11);
        step(1);
        chk("fail2_end", obs, BLUE);
        step(7);
        p_fail();
        chk("fail3_alarm", obs, WHITE);
        hold("alarm_hold", WHITE, 110);

        p_ok();
        chk("alarm_ok", obs, WHITE);
        p_lock();
        chk("alarm_lock", obs, WHITE);
        alarm_clr = 1'b1;
        step(1);
        alarm_clr = 1'b0;
        chk("alarm_clr", obs, BLUE);
        p_fail();
        chk("cnt_cleared", obs, RED);
        step(12);
        chk("cnt_cleared_end", obs, BLUE);

        evt_ok = 1'b1;
        evt_fail = 1'b1;
        step(1);
        evt_ok = 1'b0;
        evt_fail = 1'b0;
        chk("fail_beats_ok", obs, RED);
        p_ok();
        chk("fail_ignores_ok", obs, RED);
        step(11);
        chk("fail_prio_end", obs, BLUE);

        p_ok();
        p_lock();
        chk("clear_by_ok", obs, BLUE);
        setup_mode = 1'b1;
        step(1);
        chk("setup", obs, YELLOW);
        p_ok();
        chk("setup_ok", obs, YELLOW);
        hold("setup_hold", YELLOW, 30);
        setup_mode = 1'b0;
        step(1);
        chk("setup_exit", obs, BLUE);

        p_fail();
        step(7);
        p_fail();
        chk("refail", obs, RED);
        hold("refail_hold", RED, 11);
        step(1);
        chk("refail_end", obs, BLUE);

        p_ok();
        p_fail();
        chk("open_to_fail", obs, RED);
        p_fail();
        p_fail();
        chk("open_chain_alarm", obs, WHITE);

        rst = 1'b1;
        step(1);
        chk("mid_reset", obs, OFF);
        rst = 1'b0;
        step(1);
        chk("mid_reset_rel", obs, BLUE);
        p_fail();
        chk("reset_clears_cnt", obs, RED);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/led_status_seq.md
# led_status_seq

Status-indicator sequencer for the door lock: converts one-cycle events from the lock controller (password correct, password wrong, re-lock, setup mode, alarm clear) into the `led_rgb` colour code and `rgb_toggle` blink request consumed by the RGB LED driver. It sits between the lock FSM and the LED driver. It owns all indicator timing: open window, wrong-attempt display, and escalation to alarm after repeated failures.

## Interface
- `TICK_DIV`, 28'd50_000_000 — clk_in cycles per timing tick (1 s at 50 MHz); must be ≥ 2.
- `OPEN_TICKS`, 5 — ticks the GREEN open indication lasts.
- `FAIL_TICKS`, 3 — ticks the RED blink lasts after a wrong attempt.
- `MAX_FAIL`, 3 — consecutive failures that trigger the alarm; must be ≥ 1.

- `clk_in` input 1 — system clock.
- `rst` input 1 — synchronous, active-high reset.
- `evt_ok` input 1 — one-cycle pulse: password accepted.
- `evt_fail` input 1 — one-cycle pulse: password rejected.
- `evt_lock` input 1 — one-cycle pulse: door re-locked by the user.
- `setup_mode` input 1 — level: password-change mode active.
- `alarm_clr` input 1 — one-cycle pulse: admin clears the alarm.
- `led_rgb` output 3 — colour code: OFF 000, RED 001, GREEN 010, YELLOW 011, BLUE 100, WHITE 111.
- `rgb_toggle` output 1 — 1 requests blinking of `led_rgb`.
- `alarm` output 1 — high while in ALARM.
- `busy` output 1 — high in OPEN, FAIL, ALARM, SETUP.

## Operation
- States: IDLE, OPEN, FAIL, ALARM, SETUP. Output mapping:
  - IDLE: BLUE, steady.
  - OPEN: GREEN, steady.
  - FAIL: RED, blink.
  - ALARM: WHITE, blink, with `alarm`=1.
  - SETUP: YELLOW, blink.
- Prescaler: counts 0..TICK_DIV-1 and pulses `tick` at TICK_DIV-1, then wraps to 0.
- Prescaler and tick timer both clear/load on every state entry, including re-entry of the same state.
- The tick timer (≥ clog2(max(OPEN_TICKS,FAIL_TICKS)+1) bits) is loaded with the state's duration and decrements on `tick`. When a `tick` arrives with timer = 1, the timed state exits.
- Timed-state duration is therefore exactly N×TICK_DIV cycles.
- `fail_cnt`: saturating counter, clog2(MAX_FAIL+1) bits.
  - Increments on each accepted `evt_fail`.
  - Cleared on an accepted `evt_ok`, on `alarm_clr` in ALARM, and on reset.
- IDLE transitions (priority order):
  1. `evt_fail` → FAIL, or → ALARM if the increment makes `fail_cnt` = MAX_FAIL.
  2. `evt_ok` → OPEN.
  3. `setup_mode` → SETUP.
  4. `evt_lock`: no effect.
- OPEN transitions:
  - `evt_lock` → IDLE immediately.
  - `evt_fail` → FAIL/ALARM, same rule as IDLE.
  - Timeout → IDLE.
  - `evt_ok` restarts the OPEN window.
  - `setup_mode` is ignored.
- FAIL transitions:
  - `evt_fail` → re-enters FAIL with the timer reloaded and the counter incremented, or → ALARM at MAX_FAIL.
  - Timeout → IDLE.
  - `evt_ok`, `evt_lock`, `setup_mode` are ignored (lockout display).
- ALARM transitions:
  - Only `alarm_clr` leaves, → IDLE with `fail_cnt` cleared.
  - All other inputs are ignored; there is no timeout.
- SETUP transitions:
  - Leaves to IDLE when `setup_mode`=0.
  - All events are ignored.
- Simultaneous events use the priority order above: fail beats ok beats lock. `alarm_clr` outside ALARM is ignored.

## Timing
- Reset (`rst`=1 at a clk_in edge):
  - State → IDLE, `fail_cnt`=0, prescaler=0.
  - `led_rgb`=OFF, `rgb_toggle`=0, `alarm`=0, `busy`=0.
- First edge after `rst` drops: outputs become BLUE, steady.
- All outputs are registered from the next state. An event sampled at edge n is reflected on outputs after edge n (one-cycle latency). There are no combinational paths from inputs to outputs.
- `rst` mid-operation (any state, including ALARM) behaves exactly as a power-up reset; the alarm is cleared.
- Event inputs are treated as pulses sampled each cycle. A level held for k cycles counts as k events; producers guarantee one-cycle pulses.
- Tick wrap: the prescaler reaching TICK_DIV-1 in the same cycle as a state-changing event yields no decrement. The new state starts with a fresh prescaler.

## Test plan
All scenarios use TICK_DIV=4, OPEN_TICKS=5, FAIL_TICKS=3, MAX_FAIL=3.
- Reset then release → OFF/0 during reset, BLUE/steady one cycle after; `busy`=0, `alarm`=0.
- `evt_ok` pulse at cycle n → GREEN steady from n+1, `busy`=1; returns to BLUE exactly 20 cycles after entry.
- `evt_ok`, then `evt_lock` 6 cycles later → BLUE on the cycle after the lock pulse.
- Three `evt_fail` pulses spaced 20 cycles apart → RED blink for 12 cycles after each of the first two. WHITE blink with `alarm`=1 after the third; persists 100+ cycles.
- ALARM, then `evt_ok` and `evt_lock` → no change. `alarm_clr` → BLUE, `alarm`=0. A subsequent single `evt_fail` gives RED (not ALARM), confirming `fail_cnt` was cleared.
- `evt_ok` and `evt_fail` asserted in the same cycle from IDLE → FAIL (RED blink). Separately, `setup_mode`=1 → YELLOW blink; `evt_ok` is ignored; dropping `setup_mode` → BLUE next cycle.
